// File: rtl/universal_shift_reg_pkg.sv
// ----------------------------------------------------------------------------
// universal_shift_reg_pkg
//   Shared definitions for the universal shift register.
//   Holds the mode-select encoding used on the 2-bit sel input.
// ----------------------------------------------------------------------------
package universal_shift_reg_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_SHR  = 2'b01,
    MODE_SHL  = 2'b10,
    MODE_LOAD = 2'b11
  } usr_mode_e;

  localparam int unsigned MODE_W = 2;

endpackage : universal_shift_reg_pkg

// File: rtl/universal_shift_reg_bit_cell.sv
// ----------------------------------------------------------------------------
// usr_bit_cell
//   Per-bit 4:1 next-state selector for the universal shift register.
//   Purely combinational; the register itself lives in the top level.
// Ports
//   sel       in  2  mode select (see universal_shift_reg_pkg)
//   hold_bit  in  1  current value of this bit
//   right_bit in  1  value shifted in on a right shift (upper neighbour or serial in)
//   left_bit  in  1  value shifted in on a left shift (lower neighbour or serial in)
//   load_bit  in  1  parallel load value for this bit
//   nxt_bit   out 1  value this bit takes on the next rising edge
// ----------------------------------------------------------------------------
module usr_bit_cell
  import universal_shift_reg_pkg::*;
(
  input  logic [MODE_W-1:0] sel,
  input  logic              hold_bit,
  input  logic              right_bit,
  input  logic              left_bit,
  input  logic              load_bit,
  output logic              nxt_bit
);

  always_comb begin
    nxt_bit = hold_bit;
    case (usr_mode_e'(sel))
      MODE_HOLD: nxt_bit = hold_bit;
      MODE_SHR:  nxt_bit = right_bit;
      MODE_SHL:  nxt_bit = left_bit;
      MODE_LOAD: nxt_bit = load_bit;
      default:   nxt_bit = hold_bit;
    endcase
  end

endmodule : usr_bit_cell

// File: rtl/universal_shift_reg.sv
// ----------------------------------------------------------------------------
// universal_shift_reg
//   Parameterised universal shift register: hold, shift right with serial
//   fill, shift left with serial fill, parallel load. One clock of latency
//   from sampled inputs to out; out is driven straight from flops.
// Parameters
//   WIDTH    register width in bits (>= 2)
// Ports
//   clk      in   1      rising-edge clock
//   reset    in   1      synchronous, active-high; clears out, overrides sel
//   sel      in   2      00 hold, 01 shift right, 10 shift left, 11 load
//   in_load  in   WIDTH  parallel load data (used only when sel=11)
//   in       in   1      serial fill bit (used only when sel=01 or 10)
//   out      out  WIDTH  register contents
// ----------------------------------------------------------------------------
module universal_shift_reg
  import universal_shift_reg_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [MODE_W-1:0] sel,
  input  logic [WIDTH-1:0]  in_load,
  input  logic              in,
  output logic [WIDTH-1:0]  out
);

  logic [WIDTH-1:0] nxt_p0;

  // Stage p0: per-bit next-state selection. Right shift moves data toward
  // the LSB, so bit i takes bit i+1 and the MSB takes the serial input;
  // left shift is the mirror image.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic right_src;
    logic left_src;

    if (i == WIDTH - 1) begin : g_msb
      assign right_src = in;
    end else begin : g_not_msb
      assign right_src = out[i+1];
    end

    if (i == 0) begin : g_lsb
      assign left_src = in;
    end else begin : g_not_lsb
      assign left_src = out[i-1];
    end

    usr_bit_cell u_cell (
      .sel       (sel),
      .hold_bit  (out[i]),
      .right_bit (right_src),
      .left_bit  (left_src),
      .load_bit  (in_load[i]),
      .nxt_bit   (nxt_p0[i])
    );
  end

  // Stage p1: the architectural register; reset has priority over any mode.
  always_ff @(posedge clk) begin
    if (reset) begin
      out <= '0;
    end else begin
      out <= nxt_p0;
    end
  end

endmodule : universal_shift_reg

// File: tb/tb_universal_shift_reg.sv
// ----------------------------------------------------------------------------
// tb_universal_shift_reg
//   Self-checking bench for universal_shift_reg (WIDTH=4): directed sequences
//   followed by randomized mode/data traffic, compared against an arithmetic
//   reference model of the register contents.
// ----------------------------------------------------------------------------
module tb_universal_shift_reg;

  localparam int W = 4;
  localparam int MOD = 1 << W;

  logic         clk = 1'b0;
  logic         reset;
  logic [1:0]   sel;
  logic [W-1:0] in_load;
  logic         in;
  logic [W-1:0] out;

  int n_checks = 0;
  int n_pass   = 0;
  int model    = 0;

  universal_shift_reg #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset   (reset),
    .sel     (sel),
    .in_load (in_load),
    .in      (in),
    .out     (out)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [W-1:0] got,
                          input logic [W-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", tag, got, exp);
  endtask

  // Register contents as a number: right shift halves and adds the fill bit
  // at the top weight; left shift doubles, adds the fill bit, wraps mod 2^W.
  function automatic int ref_next(input int cur, input logic r, input logic [1:0] s,
                                  input logic [W-1:0] ld, input logic si);
    if (r) return 0;
    case (s)
      2'd1:    return cur / 2 + int'(si) * (MOD / 2);
      2'd2:    return (cur * 2 + int'(si)) % MOD;
      2'd3:    return int'(ld);
      default: return cur;
    endcase
  endfunction

  task automatic step(input logic r, input logic [1:0] s, input logic [W-1:0] ld,
                      input logic si);
    @(negedge clk);
    reset = r; sel = s; in_load = ld; in = si;
    @(posedge clk);
    #1;
    model = ref_next(model, r, s, ld, si);
    check_eq("model", out, W'(model));
  endtask

  initial begin
    reset = 1'b0; sel = 2'b00; in_load = '0; in = 1'b0;

    // 1. reset then hold
    step(1'b1, 2'b00, 4'b1111, 1'b1);
    check_eq("reset_clear", out, 4'b0000);
    step(1'b0, 2'b00, 4'b1111, 1'b1);
    step(1'b0, 2'b00, 4'b0110, 1'b0);
    check_eq("hold_after_reset", out, 4'b0000);

    // 2. load then hold
    step(1'b0, 2'b11, 4'b1010, 1'b0);
    check_eq("load_1010", out, 4'b1010);
    step(1'b0, 2'b00, 4'b0101, 1'b1);
    check_eq("hold_1010", out, 4'b1010);

    // 3. shift right
    step(1'b0, 2'b01, 4'b0000, 1'b1);
    check_eq("shr_in1", out, 4'b1101);
    step(1'b0, 2'b01, 4'b1111, 1'b0);
    check_eq("shr_in0", out, 4'b0110);

    // 4. shift left then hold
    step(1'b0, 2'b10, 4'b0000, 1'b1);
    check_eq("shl_in1", out, 4'b1101);
    step(1'b0, 2'b10, 4'b1111, 1'b0);
    check_eq("shl_in0", out, 4'b1010);
    step(1'b0, 2'b00, 4'b0000, 1'b1);
    check_eq("hold_after_shl", out, 4'b1010);

    // 5. reset beats load mid-operation
    step(1'b0, 2'b11, 4'b1111, 1'b0);
    check_eq("load_1111", out, 4'b1111);
    step(1'b1, 2'b11, 4'b0101, 1'b1);
    check_eq("reset_over_load", out, 4'b0000);

    // 6. ignored inputs and a full-width left fill
    step(1'b0, 2'b11, 4'b1001, 1'b0);
    step(1'b0, 2'b11, 4'b1001, 1'b1);
    check_eq("load_ignores_in", out, 4'b1001);
    step(1'b0, 2'b01, 4'b1111, 1'b0);
    check_eq("shr_ignores_load", out, 4'b0100);
    step(1'b0, 2'b10, 4'b0000, 1'b0);
    check_eq("shl_ignores_load", out, 4'b1000);
    step(1'b1, 2'b00, 4'b0000, 1'b0);
    for (int k = 0; k < W; k++) step(1'b0, 2'b10, 4'($urandom), 1'b1);
    check_eq("shl_fill_ones", out, 4'b1111);

    // Randomized traffic with occasional reset
    for (int k = 0; k < 300; k++) begin
      step(($urandom_range(0, 15) == 0), 2'($urandom_range(0, 3)),
           4'($urandom), 1'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_universal_shift_reg
